instr_assembler: RTL and testbench

- Producer side of the control unit's instruction handshake (instr_ready / instr_ack / instr_in).
- Takes a byte stream from the host UART receiver and packs each group of 4 bytes into one 32-bit instruction word.
- Buffers completed words in a small FIFO and presents them one at a time to the control unit.
- Discards partial words after an inter-byte timeout so the host can resynchronise.

---
 rtl/instr_assembler.sv | 156 +++++++++++++++
 tb/tb_instr_assembler.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_assembler.sv
// Packs a host byte stream into big-endian 32-bit instruction words and
// queues them in a small FIFO for the control unit's ready/ack handshake.
module instr_assembler #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rx_valid,
  input  logic [7:0]                    rx_data,
  output logic                          instr_ready,
  input  logic                          instr_ack,
  output logic [31:0]                   instr_in,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          timeout_drop,
  output logic                          ack_error,
  input  logic                          clear_flags
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES);

  localparam logic [0:0] EMPTY_WORD = 1'b0;
  localparam logic [0:0] COLLECT    = 1'b1;

  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  logic [0:0]       state_reg, state_next;
  logic [1:0]       byte_cnt_reg, byte_cnt_next;
  logic [23:0]      shift_reg, shift_next;
  logic [TMR_W-1:0] timer_reg, timer_next;
  logic             timeout_reg, timeout_next;
  logic             push_req;
  logic [31:0]      push_word;

  logic [31:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             overflow_reg, ack_error_reg;
  logic             fifo_empty, fifo_full, push, pop;

  // Only the first three bytes are held; the fourth goes straight into the FIFO.
  always_comb begin
    state_next    = state_reg;
    byte_cnt_next = byte_cnt_reg;
    shift_next    = shift_reg;
    timer_next    = timer_reg;
    timeout_next  = 1'b0;
    push_req      = 1'b0;
    push_word     = {shift_reg, rx_data};
    case (state_reg)
      EMPTY_WORD: begin
        if (rx_valid) begin
          shift_next    = {16'h0000, rx_data};
          byte_cnt_next = 2'd1;
          timer_next    = '0;
          state_next    = COLLECT;
        end
      end
      default: begin
        if (rx_valid) begin
          timer_next = '0;
          if (byte_cnt_reg == 2'd3) begin
            push_req      = 1'b1;
            shift_next    = '0;
            byte_cnt_next = 2'd0;
            state_next    = EMPTY_WORD;
          end else begin
            shift_next    = {shift_reg[15:0], rx_data};
            byte_cnt_next = byte_cnt_reg + 2'd1;
          end
        end else if (timer_reg == TMR_LAST) begin
          timeout_next  = 1'b1;
          shift_next    = '0;
          byte_cnt_next = 2'd0;
          timer_next    = '0;
          state_next    = EMPTY_WORD;
        end else if (timer_reg != TMR_MAX) begin
          timer_next = timer_reg + TMR_W'(1);
        end
      end
    endcase
  end

  assign fifo_empty = (count_reg == '0);
  assign fifo_full  = (count_reg == CNT_FULL);
  assign pop        = instr_ack && !fifo_empty;
  // A simultaneous pop frees the slot, so a push onto a full FIFO is still legal.
  assign push       = push_req && (!fifo_full || pop);

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= push_word;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= EMPTY_WORD;
      byte_cnt_reg  <= 2'd0;
      shift_reg     <= '0;
      timer_reg     <= '0;
      timeout_reg   <= 1'b0;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      overflow_reg  <= 1'b0;
      ack_error_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      byte_cnt_reg <= byte_cnt_next;
      shift_reg    <= shift_next;
      timer_reg    <= timer_next;
      timeout_reg  <= timeout_next;
      count_reg    <= count_next;
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      // A new set condition takes priority over clear_flags.
      if (push_req && fifo_full && !pop) begin
        overflow_reg <= 1'b1;
      end else if (clear_flags) begin
        overflow_reg <= 1'b0;
      end
      if (instr_ack && fifo_empty) begin
        ack_error_reg <= 1'b1;
      end else if (clear_flags) begin
        ack_error_reg <= 1'b0;
      end
    end
  end

  assign instr_ready  = !fifo_empty;
  assign instr_in     = fifo_empty ? 32'h0 : mem[rd_ptr_reg];
  assign fifo_count   = count_reg;
  assign overflow     = overflow_reg;
  assign timeout_drop = timeout_reg;
  assign ack_error    = ack_error_reg;

endmodule

// File: tb/tb_instr_assembler.sv
// Directed bench for instr_assembler: byte packing, timeout, FIFO full/overflow,
// push-on-pop, ack-while-empty flags and reset mid-word.
`timescale 1ns/1ps
module tb_instr_assembler;

  logic        clk;
  logic        reset;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        instr_ready;
  logic        instr_ack;
  logic [31:0] instr_in;
  logic [2:0]  fifo_count;
  logic        overflow;
  logic        timeout_drop;
  logic        ack_error;
  logic        clear_flags;

  int checks = 0;
  int errors = 0;

  instr_assembler #(
    .FIFO_DEPTH     (4),
    .TIMEOUT_CYCLES (20)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .instr_ready  (instr_ready),
    .instr_ack    (instr_ack),
    .instr_in     (instr_in),
    .fifo_count   (fifo_count),
    .overflow     (overflow),
    .timeout_drop (timeout_drop),
    .ack_error    (ack_error),
    .clear_flags  (clear_flags)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  // All drivers change on the falling edge; outputs are sampled there too.
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    logic [31:0] tmp;
    tmp = w;
    for (int i = 0; i < 4; i++) begin
      send_byte(tmp[31:24]);
      tmp = tmp << 8;
      if (i < 3) idle(gap);
    end
  endtask

  task automatic ack_pulse();
    instr_ack = 1'b1;
    @(negedge clk);
    instr_ack = 1'b0;
  endtask

  task automatic pulse_clear();
    clear_flags = 1'b1;
    @(negedge clk);
    clear_flags = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_pulse;
    int pulses;
    logic [31:0] exp_words [4];

    reset       = 1'b1;
    rx_valid    = 1'b0;
    rx_data     = 8'h00;
    instr_ack   = 1'b0;
    clear_flags = 1'b0;
    idle(2);
    check("rst_ready", instr_ready, 0);
    check("rst_instr", instr_in, 0);
    check("rst_count", fifo_count, 0);
    check("rst_flags", {overflow, timeout_drop, ack_error}, 0);
    reset = 1'b0;
    idle(1);

    // Byte order, with 3-cycle gaps
    send_byte(8'h08); idle(3);
    send_byte(8'h12); idle(3);
    send_byte(8'h34); idle(3);
    check("order_not_ready_yet", instr_ready, 0);
    send_byte(8'h56);
    check("order_ready", instr_ready, 1);
    check("order_word", instr_in, 32'h08123456);
    check("order_count", fifo_count, 1);
    ack_pulse();
    check("order_pop_ready", instr_ready, 0);
    check("order_pop_count", fifo_count, 0);
    check("order_pop_instr", instr_in, 0);

    // Inter-byte timeout: pulse expected on the 20th idle edge after the last byte
    send_byte(8'h11);
    send_byte(8'h22);
    first_pulse = 0;
    pulses = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (timeout_drop) begin
        pulses++;
        if (first_pulse == 0) first_pulse = i;
      end
    end
    check("timeout_cycle", first_pulse, 20);
    check("timeout_pulses", pulses, 1);
    check("timeout_no_word", fifo_count, 0);
    send_word(32'hAABBCCDD, 0);
    check("after_timeout_word", instr_in, 32'hAABBCCDD);
    check("after_timeout_count", fifo_count, 1);
    ack_pulse();

    // Byte landing on the timeout edge wins
    send_byte(8'h77);
    idle(19);
    send_byte(8'h66);
    check("tie_no_drop", timeout_drop, 0);
    send_byte(8'h55);
    send_byte(8'h44);
    check("tie_word", instr_in, 32'h77665544);
    ack_pulse();
    check("tie_empty", fifo_count, 0);

    // Fill the FIFO, fifth word overflows
    for (int w = 1; w <= 4; w++) send_word({4{8'(w)}}, 0);
    check("fill_count4", fifo_count, 4);
    check("fill_no_ovf", overflow, 0);
    send_word(32'h05050505, 0);
    check("fill_ovf_count", fifo_count, 4);
    check("fill_ovf_flag", overflow, 1);
    for (int w = 1; w <= 4; w++) begin
      check($sformatf("fill_pop%0d", w), instr_in, {4{8'(w)}});
      ack_pulse();
    end
    check("fill_drained", instr_ready, 0);
    check("fill_ovf_sticky", overflow, 1);
    pulse_clear();
    check("fill_ovf_cleared", overflow, 0);

    // Push on the same edge as a pop while full
    for (int w = 0; w < 4; w++) send_word(32'hA0000001 + w, 1);
    check("pop_push_full", fifo_count, 4);
    send_byte(8'hCA);
    send_byte(8'hFE);
    send_byte(8'hF0);
    instr_ack = 1'b1;
    send_byte(8'h0D);
    instr_ack = 1'b0;
    check("pop_push_count", fifo_count, 4);
    check("pop_push_no_ovf", overflow, 0);
    exp_words[0] = 32'hA0000002;
    exp_words[1] = 32'hA0000003;
    exp_words[2] = 32'hA0000004;
    exp_words[3] = 32'hCAFEF00D;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("pop_push_order%0d", k), instr_in, exp_words[k]);
      ack_pulse();
    end
    check("pop_push_empty", fifo_count, 0);

    // Ack while empty, clear, and clear racing a new set
    check("empty_ack_err_before", ack_error, 0);
    ack_pulse();
    check("empty_ack_err", ack_error, 1);
    check("empty_ack_count", fifo_count, 0);
    send_word(32'h55667788, 0);
    check("empty_ack_ptr_word", instr_in, 32'h55667788);
    ack_pulse();
    pulse_clear();
    check("empty_ack_cleared", ack_error, 0);
    instr_ack   = 1'b1;
    clear_flags = 1'b1;
    @(negedge clk);
    instr_ack   = 1'b0;
    clear_flags = 1'b0;
    check("set_beats_clear", ack_error, 1);

    // Reset mid-word with one buffered word and a sticky flag
    send_word(32'h12345678, 0);
    send_byte(8'h9A);
    send_byte(8'hBC);
    check("pre_reset_count", fifo_count, 1);
    reset = 1'b1;
    #1;
    check("reset_async_ready", instr_ready, 0);
    @(negedge clk);
    reset = 1'b0;
    check("reset_instr", instr_in, 0);
    check("reset_count", fifo_count, 0);
    check("reset_flags", {overflow, timeout_drop, ack_error}, 0);
    send_word(32'hDEADBEEF, 0);
    check("reset_fresh_word", instr_in, 32'hDEADBEEF);
    check("reset_fresh_count", fifo_count, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
